// File: rtl/pwm_pkg.sv
// Shared types and helpers for the complementary PWM generator.
// Compare arithmetic is done in a fixed 33-bit word so WIDTH+1-bit results never overflow.
package pwm_pkg;

  localparam int PWM_WIDTH_DEF = 12;
  localparam int PWM_NCH_DEF   = 3;
  localparam int PWM_DT_W_DEF  = 8;
  localparam int PWM_CW        = 33;

  typedef logic [PWM_CW-1:0] pwm_word_t;

  typedef struct packed {
    pwm_word_t period;
    pwm_word_t deadtime;
  } pwm_cfg_t;

  // Duty clamped to the period length; duty beyond it just means "high to the end".
  function automatic pwm_word_t d_eff(input pwm_word_t duty, input pwm_word_t per);
    pwm_word_t lim;
    lim = per + pwm_word_t'(1);
    return (duty < lim) ? duty : lim;
  endfunction

endpackage

// File: rtl/pwm_comp_chan.sv
// One complementary channel: dead-time aware compare against the shared counter,
// with registered high-side and low-side outputs.
module pwm_comp_chan
  import pwm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run_i,
  input  logic [PWM_CW-1:0] cnt_i,
  input  logic [PWM_CW-1:0] per_i,
  input  logic [PWM_CW-1:0] dt_i,
  input  logic [PWM_CW-1:0] duty_i,
  output logic              hi_o,
  output logic              lo_o
);

  pwm_word_t deff;
  pwm_word_t lo_start;
  logic      hi_d, lo_d;
  logic      hi_q, lo_q;

  // lo rises only after dt cycles past the hi falling edge.
  always_comb begin
    deff     = d_eff(duty_i, per_i);
    lo_start = deff + dt_i;
    hi_d     = run_i && (cnt_i >= dt_i) && (cnt_i < deff);
    lo_d     = run_i && (cnt_i >= lo_start);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= 1'b0;
      lo_q <= 1'b0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/pwm_comp_gen.sv
// Multi-channel complementary PWM generator: shared counter, double-buffered period,
// dead time and duty. Optional fault latch enabled by defining PWM_FAULT_EN.
module pwm_comp_gen
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH_DEF,
  parameter int NCH   = PWM_NCH_DEF,
  parameter int DT_W  = PWM_DT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 wr,
  input  logic [WIDTH-1:0]     period,
  input  logic [DT_W-1:0]      deadtime,
  input  logic [NCH*WIDTH-1:0] duty,
`ifdef PWM_FAULT_EN
  input  logic                 fault,
  input  logic                 fault_clr,
  output logic                 fault_sts,
`endif
  output logic [NCH-1:0]       pwm_hi,
  output logic [NCH-1:0]       pwm_lo,
  output logic                 period_end
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  pwm_cfg_t         shadow_cfg_q, shadow_cfg_d;
  pwm_cfg_t         act_cfg_q;
  logic             period_end_q;
  pwm_word_t        cnt_x;
  logic             wrap;
  logic             load_act;
  logic             run;

  assign cnt_x    = {{(PWM_CW-WIDTH){1'b0}}, cnt_q};
  assign wrap     = en && (cnt_x == act_cfg_q.period);
  assign load_act = wrap || !en;

  always_comb begin
    cnt_d = cnt_q + WIDTH'(1);
    if (load_act) begin
      cnt_d = '0;
    end
    shadow_cfg_d = shadow_cfg_q;
    if (wr) begin
      shadow_cfg_d.period   = {{(PWM_CW-WIDTH){1'b0}}, period};
      shadow_cfg_d.deadtime = {{(PWM_CW-DT_W){1'b0}}, deadtime};
    end
  end

  // Active registers sample the shadow before this edge's write lands in it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      shadow_cfg_q <= '0;
      act_cfg_q    <= '0;
      period_end_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      shadow_cfg_q <= shadow_cfg_d;
      if (load_act) begin
        act_cfg_q <= shadow_cfg_q;
      end
      period_end_q <= wrap;
    end
  end

  assign period_end = period_end_q;

`ifdef PWM_FAULT_EN
  logic fault_sts_q, fault_sts_d;
  logic block_q, block_d;

  // Blocking outlives the status bit until the next period start.
  always_comb begin
    fault_sts_d = fault_sts_q;
    if (fault) begin
      fault_sts_d = 1'b1;
    end else if (fault_clr) begin
      fault_sts_d = 1'b0;
    end
    block_d = block_q;
    if (fault) begin
      block_d = 1'b1;
    end else if (load_act && !fault_sts_d) begin
      block_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_sts_q <= 1'b0;
      block_q     <= 1'b0;
    end else begin
      fault_sts_q <= fault_sts_d;
      block_q     <= block_d;
    end
  end

  assign fault_sts = fault_sts_q;
  assign run       = en && !fault && !block_q;
`else
  assign run = en;
`endif

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    logic [WIDTH-1:0] shadow_duty_q, shadow_duty_d;
    logic [WIDTH-1:0] act_duty_q;

    assign shadow_duty_d = wr ? duty[gi*WIDTH +: WIDTH] : shadow_duty_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        shadow_duty_q <= '0;
        act_duty_q    <= '0;
      end else begin
        shadow_duty_q <= shadow_duty_d;
        if (load_act) begin
          act_duty_q <= shadow_duty_q;
        end
      end
    end

    pwm_comp_chan u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .run_i  (run),
      .cnt_i  (cnt_x),
      .per_i  (act_cfg_q.period),
      .dt_i   (act_cfg_q.deadtime),
      .duty_i ({{(PWM_CW-WIDTH){1'b0}}, act_duty_q}),
      .hi_o   (pwm_hi[gi]),
      .lo_o   (pwm_lo[gi])
    );
  end

endmodule

// File: tb/tb_pwm_comp_gen.sv
// Self-checking bench for pwm_comp_gen: cycle reference model plus directed period counts.
// Fault scenarios are exercised when PWM_FAULT_EN is defined.
module tb_pwm_comp_gen;

  localparam int W   = 12;
  localparam int NCH = 3;
  localparam int DTW = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               en = 1'b0;
  logic               wr = 1'b0;
  logic [W-1:0]       period = '0;
  logic [DTW-1:0]     deadtime = '0;
  logic [NCH*W-1:0]   duty = '0;
  logic [NCH-1:0]     pwm_hi, pwm_lo;
  logic               period_end;
`ifdef PWM_FAULT_EN
  logic               fault = 1'b0;
  logic               fault_clr = 1'b0;
  logic               fault_sts;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state
  int m_cnt, m_sh_per, m_sh_dt, m_act_per, m_act_dt;
  int m_sh_duty[NCH];
  int m_act_duty[NCH];
  bit m_sts, m_block;
  logic [NCH-1:0] exp_hi, exp_lo;
  logic exp_pe;
  int hi_n[NCH];
  int lo_n[NCH];
  int pe_n;

  pwm_comp_gen #(.WIDTH(W), .NCH(NCH), .DT_W(DTW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .wr         (wr),
    .period     (period),
    .deadtime   (deadtime),
    .duty       (duty),
`ifdef PWM_FAULT_EN
    .fault      (fault),
    .fault_clr  (fault_clr),
    .fault_sts  (fault_sts),
`endif
    .pwm_hi     (pwm_hi),
    .pwm_lo     (pwm_lo),
    .period_end (period_end)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_cnt = 0; m_sh_per = 0; m_sh_dt = 0; m_act_per = 0; m_act_dt = 0;
    m_sts = 0; m_block = 0;
    for (int c = 0; c < NCH; c++) begin
      m_sh_duty[c] = 0;
      m_act_duty[c] = 0;
    end
  endtask

  // Expected outputs after the coming edge, from the pre-edge model state and inputs.
  task automatic model_edge();
    bit gate;
    bit wrap;
    bit sts_n;
    int deff;
    gate = 1'b1;
`ifdef PWM_FAULT_EN
    gate = !fault && !m_block;
`endif
    for (int c = 0; c < NCH; c++) begin
      deff = (m_act_duty[c] < m_act_per + 1) ? m_act_duty[c] : m_act_per + 1;
      exp_hi[c] = en && gate && (m_cnt >= m_act_dt) && (m_cnt < deff);
      exp_lo[c] = en && gate && (m_cnt >= deff + m_act_dt);
    end
    wrap   = en && (m_cnt == m_act_per);
    exp_pe = wrap;
`ifdef PWM_FAULT_EN
    sts_n = fault ? 1'b1 : (fault_clr ? 1'b0 : m_sts);
    if (fault) m_block = 1'b1;
    else if ((wrap || !en) && !sts_n) m_block = 1'b0;
    m_sts = sts_n;
`else
    sts_n = 1'b0;
    m_sts = sts_n;
`endif
    if (wrap || !en) begin
      m_act_per = m_sh_per;
      m_act_dt  = m_sh_dt;
      for (int c = 0; c < NCH; c++) m_act_duty[c] = m_sh_duty[c];
    end
    m_cnt = (!en || wrap) ? 0 : m_cnt + 1;
    if (wr) begin
      m_sh_per = int'(period);
      m_sh_dt  = int'(deadtime);
      for (int c = 0; c < NCH; c++) m_sh_duty[c] = int'(duty[c*W +: W]);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (pwm_hi !== exp_hi) begin
      tests_failed++;
      $display("FAIL pwm_hi: got %b want %b at %0t", pwm_hi, exp_hi, $time);
    end
    tests_run++;
    if (pwm_lo !== exp_lo) begin
      tests_failed++;
      $display("FAIL pwm_lo: got %b want %b at %0t", pwm_lo, exp_lo, $time);
    end
    tests_run++;
    if (period_end !== exp_pe) begin
      tests_failed++;
      $display("FAIL period_end: got %b want %b at %0t", period_end, exp_pe, $time);
    end
    tests_run++;
    if ((pwm_hi & pwm_lo) !== '0) begin
      tests_failed++;
      $display("FAIL overlap: hi %b lo %b want no common bit at %0t", pwm_hi, pwm_lo, $time);
    end
`ifdef PWM_FAULT_EN
    tests_run++;
    if (fault_sts !== m_sts) begin
      tests_failed++;
      $display("FAIL fault_sts: got %b want %b at %0t", fault_sts, m_sts, $time);
    end
`endif
    for (int c = 0; c < NCH; c++) begin
      hi_n[c] += int'(pwm_hi[c]);
      lo_n[c] += int'(pwm_lo[c]);
    end
    pe_n += int'(period_end);
  endtask

  task automatic clear_counts();
    for (int c = 0; c < NCH; c++) begin
      hi_n[c] = 0;
      lo_n[c] = 0;
    end
    pe_n = 0;
  endtask

  task automatic run_to(input int c, input int budget);
    int k;
    k = 0;
    while (m_cnt != c && k < budget) begin
      step();
      k++;
    end
    tests_run++;
    if (m_cnt != c) begin
      tests_failed++;
      $display("FAIL run_to: counter at %0d want %0d within %0d cycles", m_cnt, c, budget);
    end
  endtask

  task automatic write_cfg(input int per, input int dt, input int d0, input int d1, input int d2);
    period   = W'(per);
    deadtime = DTW'(dt);
    duty[0*W +: W] = W'(d0);
    duty[1*W +: W] = W'(d1);
    duty[2*W +: W] = W'(d2);
    wr = 1'b1;
    step();
    wr = 1'b0;
  endtask

  task automatic check_count(input string name, input int got, input int want);
    tests_run++;
    if (got != want) begin
      tests_failed++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests_run++;
    if (pwm_hi !== '0 || pwm_lo !== '0 || period_end !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: hi %b lo %b pe %b want all 0", pwm_hi, pwm_lo, period_end);
    end
    rst_n = 1'b1;
    model_reset();
    repeat (3) step();
    $display("[TB] reset done");
  endtask

  task automatic test_basic();
    en = 1'b0;
    write_cfg(99, 4, 30, 45, 70);
    step();
    en = 1'b1;
    clear_counts();
    repeat (100) step();
    check_count("t1_hi_cycles", hi_n[0], 26);
    check_count("t1_lo_cycles", lo_n[0], 66);
    check_count("t1_period_end", pe_n, 1);
    check_count("t1_ch1_hi", hi_n[1], 41);
    $display("[TB] basic period: hi %0d lo %0d", hi_n[0], lo_n[0]);
  endtask

  task automatic test_update();
    run_to(50, 200);
    write_cfg(99, 4, 60, 45, 70);
    run_to(0, 200);
    clear_counts();
    repeat (100) step();
    check_count("t2_next_period_hi", hi_n[0], 56);
    run_to(99, 200);
    write_cfg(99, 4, 10, 45, 70);
    clear_counts();
    repeat (100) step();
    check_count("t2_wrap_write_old", hi_n[0], 56);
    clear_counts();
    repeat (100) step();
    check_count("t2_wrap_write_new", hi_n[0], 6);
    $display("[TB] update timing checked");
  endtask

  task automatic test_boundary();
    run_to(50, 200);
    write_cfg(99, 4, 3, 200, 50);
    run_to(0, 200);
    clear_counts();
    repeat (100) step();
    check_count("t3_short_hi", hi_n[0], 0);
    check_count("t3_short_lo", lo_n[0], 93);
    check_count("t3_long_hi", hi_n[1], 96);
    check_count("t3_long_lo", lo_n[1], 0);
    run_to(50, 200);
    write_cfg(99, 0, 50, 50, 50);
    run_to(0, 200);
    clear_counts();
    for (int k = 0; k < 100; k++) begin
      step();
      tests_run++;
      if (pwm_hi !== ~pwm_lo) begin
        tests_failed++;
        $display("FAIL t4_complement: hi %b lo %b", pwm_hi, pwm_lo);
      end
    end
    check_count("t4_hi_cycles", hi_n[0], 50);
    $display("[TB] boundaries checked");
  endtask

  task automatic test_enable();
    write_cfg(99, 4, 30, 45, 70);
    run_to(0, 300);
    step();
    run_to(40, 200);
    en = 1'b0;
    step();
    tests_run++;
    if (pwm_hi !== '0 || pwm_lo !== '0) begin
      tests_failed++;
      $display("FAIL t5_en_drop: hi %b lo %b want 0", pwm_hi, pwm_lo);
    end
    step();
    en = 1'b1;
    clear_counts();
    repeat (100) step();
    check_count("t5_restart_hi", hi_n[0], 26);
    run_to(60, 200);
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (pwm_hi !== '0 || pwm_lo !== '0 || period_end !== 1'b0) begin
      tests_failed++;
      $display("FAIL t5_async_reset: hi %b lo %b pe %b want 0", pwm_hi, pwm_lo, period_end);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step();
    tests_run++;
    if (pwm_lo !== '1) begin
      tests_failed++;
      $display("FAIL t5_cleared_shadow: lo %b want 111", pwm_lo);
    end
    repeat (5) step();
    $display("[TB] enable and reset checked");
  endtask

`ifdef PWM_FAULT_EN
  task automatic test_fault();
    write_cfg(99, 4, 30, 45, 70);
    run_to(0, 300);
    step();
    run_to(20, 200);
    fault = 1'b1;
    step();
    fault = 1'b0;
    tests_run++;
    if (pwm_hi !== '0 || pwm_lo !== '0 || fault_sts !== 1'b1) begin
      tests_failed++;
      $display("FAIL t6_fault_set: hi %b lo %b sts %b want 0 0 1", pwm_hi, pwm_lo, fault_sts);
    end
    run_to(70, 200);
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    run_to(0, 200);
    clear_counts();
    repeat (100) step();
    check_count("t6_resume_hi", hi_n[0], 26);
    $display("[TB] fault latch checked");
  endtask
`endif

  task automatic test_random();
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 19) == 0) begin
        period   = W'($urandom_range(0, 40));
        deadtime = DTW'($urandom_range(0, 15));
        for (int c = 0; c < NCH; c++) duty[c*W +: W] = W'($urandom_range(0, 50));
        wr = 1'b1;
      end
      if (en && $urandom_range(0, 199) == 0) en = 1'b0;
      else if (!en && $urandom_range(0, 4) == 0) en = 1'b1;
`ifdef PWM_FAULT_EN
      fault     = ($urandom_range(0, 299) == 0);
      fault_clr = ($urandom_range(0, 29) == 0);
`endif
      step();
      wr = 1'b0;
    end
`ifdef PWM_FAULT_EN
    fault = 1'b0;
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
`endif
    en = 1'b1;
    $display("[TB] random stimulus done");
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 60; k++) begin
      period   = W'($urandom_range(0, 20));
      deadtime = DTW'($urandom_range(0, 6));
      for (int c = 0; c < NCH; c++) duty[c*W +: W] = W'($urandom_range(0, 25));
      wr = 1'b1;
      step();
    end
    wr = 1'b0;
    repeat (60) step();
    $display("[TB] back-to-back writes done");
  endtask

  initial begin
    model_reset();
    clear_counts();
    test_reset();
    test_basic();
    test_update();
    test_boundary();
    test_enable();
`ifdef PWM_FAULT_EN
    test_fault();
`endif
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
